// File: rtl/d_tree.sv
// d_tree: fixed depth-4 binary decision-tree classifier, 30 x 10-bit features -> 5-bit label.
// Optional input register stage enabled by defining DTREE_INPUT_REG_EN (latency 2 instead of 1).
module d_tree (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in0,
    input  logic [9:0] in1,
    input  logic [9:0] in2,
    input  logic [9:0] in3,
    input  logic [9:0] in4,
    input  logic [9:0] in5,
    input  logic [9:0] in6,
    input  logic [9:0] in7,
    input  logic [9:0] in8,
    input  logic [9:0] in9,
    input  logic [9:0] in10,
    input  logic [9:0] in11,
    input  logic [9:0] in12,
    input  logic [9:0] in13,
    input  logic [9:0] in14,
    input  logic [9:0] in15,
    input  logic [9:0] in16,
    input  logic [9:0] in17,
    input  logic [9:0] in18,
    input  logic [9:0] in19,
    input  logic [9:0] in20,
    input  logic [9:0] in21,
    input  logic [9:0] in22,
    input  logic [9:0] in23,
    input  logic [9:0] in24,
    input  logic [9:0] in25,
    input  logic [9:0] in26,
    input  logic [9:0] in27,
    input  logic [9:0] in28,
    input  logic [9:0] in29,
    output logic [4:0] out0
);

    logic [29:0][9:0] feat_d;
    logic [29:0][9:0] feat;

    assign feat_d = {in29, in28, in27, in26, in25, in24, in23, in22, in21, in20,
                     in19, in18, in17, in16, in15, in14, in13, in12, in11, in10,
                     in9,  in8,  in7,  in6,  in5,  in4,  in3,  in2,  in1,  in0};

`ifdef DTREE_INPUT_REG_EN
    logic [29:0][9:0] feat_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q <= '0;
        end else begin
            feat_q <= feat_d;
        end
    end

    assign feat = feat_q;
`else
    assign feat = feat_d;
`endif

    // Features off every path are tied into a reduction so they are visibly consumed.
    logic unused_feat;
    assign unused_feat = ^{feat[6:1], feat[13:9], feat[20:18], feat[29]};

    // Every node compares in parallel; node n = 2^L - 1 + p in breadth-first order.
    logic [14:0] node_dec;

    for (genvar l = 0; l < 4; l++) begin : g_lvl
        for (genvar p = 0; p < (1 << l); p++) begin : g_node
            localparam int         F = 7 * l + p;
            localparam logic [9:0] T = 10'(128 * (l + 1) + 32 * p);
            assign node_dec[(1 << l) - 1 + p] = (feat[F] >= T);
        end
    end

    logic [1:0] dec1;
    logic [3:0] dec2;
    logic [7:0] dec3;

    assign dec1 = node_dec[2:1];
    assign dec2 = node_dec[6:3];
    assign dec3 = node_dec[14:7];

    // Each level's taken prefix selects the decision of the next level.
    logic b3, b2, b1, b0;
    logic [3:0] path;

    assign b3   = node_dec[0];
    assign b2   = dec1[b3];
    assign b1   = dec2[{b3, b2}];
    assign b0   = dec3[{b3, b2, b1}];
    assign path = {b3, b2, b1, b0};

    logic [4:0] out0_d;
    logic [4:0] out0_q;

    always_comb begin
        out0_d = {1'b0, path} + 5'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q <= '0;
        end else begin
            out0_q <= out0_d;
        end
    end

    assign out0 = out0_q;

endmodule

// File: tb/tb_d_tree.sv
// tb_d_tree: directed self-checking bench for d_tree; honours DTREE_INPUT_REG_EN for latency.
module tb_d_tree;

`ifdef DTREE_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] in_v [30];
    logic [4:0] out0;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-derived labels for vectors 0..9 built by load_vec.
    int exp_tab [NVEC] = '{1, 16, 9, 1, 16, 15, 1, 5, 12, 3};

    always #5 clk = ~clk;

    d_tree dut (
        .clk (clk),        .rst (rst),
        .in0 (in_v[0]),    .in1 (in_v[1]),    .in2 (in_v[2]),    .in3 (in_v[3]),
        .in4 (in_v[4]),    .in5 (in_v[5]),    .in6 (in_v[6]),    .in7 (in_v[7]),
        .in8 (in_v[8]),    .in9 (in_v[9]),    .in10(in_v[10]),   .in11(in_v[11]),
        .in12(in_v[12]),   .in13(in_v[13]),   .in14(in_v[14]),   .in15(in_v[15]),
        .in16(in_v[16]),   .in17(in_v[17]),   .in18(in_v[18]),   .in19(in_v[19]),
        .in20(in_v[20]),   .in21(in_v[21]),   .in22(in_v[22]),   .in23(in_v[23]),
        .in24(in_v[24]),   .in25(in_v[25]),   .in26(in_v[26]),   .in27(in_v[27]),
        .in28(in_v[28]),   .in29(in_v[29]),
        .out0(out0)
    );

    task automatic set_all(input logic [9:0] v);
        for (int i = 0; i < 30; i++) in_v[i] = v;
    endtask

    task automatic check(input string tag, input logic [4:0] expv);
        n_checks++;
        assert (out0 === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, out0, expv);
        end
    endtask

    task automatic load_vec(input int id);
        set_all(10'h000);
        case (id)
            0: ;
            1: set_all(10'h3FF);
            2: in_v[0] = 10'd128;
            3: in_v[0] = 10'd127;
            4: begin
                in_v[0] = 10'd128; in_v[8] = 10'd288; in_v[17] = 10'd480; in_v[28] = 10'd736;
            end
            5: begin
                in_v[0] = 10'd128; in_v[8] = 10'd288; in_v[17] = 10'd480; in_v[28] = 10'd735;
            end
            6: begin
                for (int i = 1; i <= 6; i++)   in_v[i] = 10'h3FF;
                for (int i = 9; i <= 13; i++)  in_v[i] = 10'h3FF;
                for (int i = 18; i <= 20; i++) in_v[i] = 10'h3FF;
                in_v[29] = 10'h3FF;
            end
            7: in_v[7] = 10'd256;
            8: begin
                in_v[0] = 10'd500; in_v[8] = 10'd287; in_v[16] = 10'd448; in_v[26] = 10'd672;
            end
            9: begin
                in_v[14] = 10'd384; in_v[22] = 10'd543;
            end
            default: ;
        endcase
    endtask

    initial begin
        // Reset held for two edges with arbitrary inputs.
        rst = 1'b1;
        set_all(10'h2AA);
        @(posedge clk); #1 check("reset_edge0", 5'd0);
        @(posedge clk); #1 check("reset_edge1", 5'd0);

        // Release with all-ones inputs; the captured stage still holds zeros for one edge.
        @(negedge clk);
        rst = 1'b0;
        set_all(10'h3FF);
`ifdef DTREE_INPUT_REG_EN
        @(posedge clk); #1 check("release_zero_stage", 5'd1);
`endif
        @(posedge clk); #1 check("release_first", 5'd16);

        // Back-to-back streaming: each label must appear exactly LAT edges after its vector.
        for (int c = 0; c < NVEC + LAT - 1; c++) begin
            @(negedge clk);
            if (c < NVEC) load_vec(c);
            @(posedge clk); #1;
            if (c >= LAT - 1) check($sformatf("stream_vec%0d", c - LAT + 1), 5'(exp_tab[c - LAT + 1]));
        end

        // Mid-stream reset overrides data presented in the same cycle.
        @(negedge clk);
        load_vec(4);
        rst = 1'b1;
        @(posedge clk); #1 check("midstream_reset", 5'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1 check("after_midstream_reset", 5'd16);

        // Single vector then hold: output remains stable.
        @(negedge clk);
        load_vec(9);
        repeat (LAT + 2) @(posedge clk);
        #1 check("hold_stable", 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
